// File: rtl/fpu_ftoi_pipe.sv
// ============================================================================
// Module  : fpu_ftoi_pipe
// Purpose : Two-stage binary32 -> signed int32 converter (truncate toward zero)
//           with valid/ready handshake on both sides. Define FTOI_SAT_EN for
//           saturating overflow results plus an ovf output.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module fpu_ftoi_pipe #(
   parameter logic [31:0] OVF_VALUE = 32'h80000000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] x,
   input  logic        in_valid,
   output logic        in_ready,
   output logic [31:0] y,
   output logic        out_valid,
   input  logic        out_ready
`ifdef FTOI_SAT_EN
   ,
   output logic        ovf
`endif
);

   logic        r_v1;
   logic        r_s1;
   logic [31:0] r_mag1;
   logic        r_ovf1;
   logic        r_v2;
   logic [31:0] r_y;

   logic        w_adv1;
   logic        w_adv2;
   logic        w_s;
   logic [7:0]  w_e;
   logic [22:0] w_m;
   logic [23:0] w_sig;
   logic [7:0]  w_rsh;
   logic [7:0]  w_lsh;
   logic [31:0] w_mag;
   logic        w_ovf;
   logic [31:0] w_r;
   logic [31:0] w_y_next;

   assign w_adv2    = ~r_v2 | out_ready;
   assign w_adv1    = ~r_v1 | w_adv2;
   assign in_ready  = w_adv1;
   assign out_valid = r_v2;
   assign y         = r_y;

   assign w_s   = x[31];
   assign w_e   = x[30:23];
   assign w_m   = x[22:0];
   assign w_sig = {1'b1, w_m};
   assign w_rsh = 8'd150 - w_e;
   assign w_lsh = w_e - 8'd150;

   // Only e==158 with s=1, m=0 (exactly -2^31) is representable at that exponent.
   always_comb begin
      w_mag = 32'd0;
      w_ovf = 1'b0;
      if (w_e < 8'd127) begin
         w_mag = 32'd0;
      end else if (w_e <= 8'd150) begin
         w_mag = {8'd0, w_sig} >> w_rsh;
      end else if (w_e <= 8'd157) begin
         w_mag = {8'd0, w_sig} << w_lsh;
      end else if ((w_e == 8'd158) && w_s && (w_m == 23'd0)) begin
         w_mag = 32'h80000000;
      end else begin
         w_ovf = 1'b1;
      end
   end

   assign w_r = r_s1 ? (~r_mag1 + 32'd1) : r_mag1;

`ifdef FTOI_SAT_EN
   logic w_nan;
   logic r_nan1;
   logic r_ovf;

   assign w_nan    = (w_e == 8'hFF) && (w_m != 23'd0);
   assign w_y_next = r_ovf1 ? ((r_nan1 || !r_s1) ? 32'h7FFFFFFF : 32'h80000000) : w_r;
   assign ovf      = r_ovf;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_nan1 <= 1'b0;
         r_ovf  <= 1'b0;
      end else begin
         if (w_adv1) r_nan1 <= w_nan;
         if (w_adv2) r_ovf  <= r_ovf1;
      end
   end
`else
   assign w_y_next = r_ovf1 ? OVF_VALUE : w_r;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_v1   <= 1'b0;
         r_s1   <= 1'b0;
         r_mag1 <= 32'd0;
         r_ovf1 <= 1'b0;
         r_v2   <= 1'b0;
         r_y    <= 32'd0;
      end else begin
         if (w_adv1) begin
            r_v1   <= in_valid;
            r_s1   <= w_s;
            r_mag1 <= w_mag;
            r_ovf1 <= w_ovf;
         end
         if (w_adv2) begin
            r_v2 <= r_v1;
            r_y  <= w_y_next;
         end
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_fpu_ftoi_pipe.sv
// Scoreboard bench for fpu_ftoi_pipe: driver pushes expected results, monitor pops on each output transfer.
`default_nettype none

module tb_fpu_ftoi_pipe;

`ifdef FTOI_SAT_EN
   localparam bit SAT = 1'b1;
`else
   localparam bit SAT = 1'b0;
`endif

   typedef struct packed {
      logic [31:0] y;
      logic        ovf;
   } exp_t;

   typedef struct packed {
      logic [31:0] xv;
      logic [31:0] yp;
      logic [31:0] ys;
      logic        o;
   } vec_t;

   logic        clk;
   logic        rst;
   logic [31:0] x;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] y;
   logic        out_valid;
   logic        out_ready;
   logic        ovf_w;

   exp_t q[$];
   int   checks;
   int   fails;
   int   pops;
   logic        have_hold;
   logic [31:0] held_y;

`ifdef FTOI_SAT_EN
   fpu_ftoi_pipe dut (
      .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .in_ready(in_ready),
      .y(y), .out_valid(out_valid), .out_ready(out_ready), .ovf(ovf_w)
   );
`else
   fpu_ftoi_pipe dut (
      .clk(clk), .rst(rst), .x(x), .in_valid(in_valid), .in_ready(in_ready),
      .y(y), .out_valid(out_valid), .out_ready(out_ready)
   );
   assign ovf_w = 1'b0;
`endif

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [32:0] act, input logic [32:0] exp);
      checks++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic send(input vec_t v);
      exp_t e;
      bit   done;
      done  = 1'b0;
      e.y   = SAT ? v.ys : v.yp;
      e.ovf = SAT ? v.o : 1'b0;
      x        = v.xv;
      in_valid = 1'b1;
      for (int i = 0; i < 50 && !done; i++) begin
         #1;
         if (in_ready) begin
            q.push_back(e);
            done = 1'b1;
         end
         @(negedge clk);
      end
      if (!done) begin
         checks++;
         fails++;
         $display("FAIL accept_timeout: x=%h never accepted", v.xv);
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 60 && q.size() != 0; i++) @(negedge clk);
      chk("drain_queue_empty", 33'(q.size()), 33'd0);
   endtask

   // Monitor: transfer happens at the coming posedge when out_valid & out_ready.
   always begin
      @(negedge clk);
      #2;
      if (rst) begin
         have_hold = 1'b0;
      end else if (out_valid) begin
         if (have_hold) chk("stall_y_stable", {1'b0, y}, {1'b0, held_y});
         if (out_ready) begin
            have_hold = 1'b0;
            if (q.size() == 0) begin
               checks++;
               fails++;
               $display("FAIL unexpected_output: got y=%h with empty scoreboard", y);
            end else begin
               exp_t e;
               e = q.pop_front();
               pops++;
               chk("result_y_ovf", {y, ovf_w}, {e.y, e.ovf});
            end
         end else begin
            have_hold = 1'b1;
            held_y    = y;
         end
      end else begin
         have_hold = 1'b0;
      end
   end

   vec_t vecs[17];
   vec_t strm[8];
   int   p0;

   initial begin
      checks = 0; fails = 0; pops = 0; have_hold = 1'b0; held_y = '0;
      rst = 1'b1; x = '0; in_valid = 1'b0; out_ready = 1'b1;

      vecs[0]  = '{32'hC0200000, 32'hFFFFFFFE, 32'hFFFFFFFE, 1'b0};
      vecs[1]  = '{32'h3F7FFFFF, 32'h00000000, 32'h00000000, 1'b0};
      vecs[2]  = '{32'hCF000000, 32'h80000000, 32'h80000000, 1'b0};
      vecs[3]  = '{32'h4F000000, 32'h80000000, 32'h7FFFFFFF, 1'b1};
      vecs[4]  = '{32'h7FC00000, 32'h80000000, 32'h7FFFFFFF, 1'b1};
      vecs[5]  = '{32'hFFC00000, 32'h80000000, 32'h7FFFFFFF, 1'b1};
      vecs[6]  = '{32'hBF000000, 32'h00000000, 32'h00000000, 1'b0};
      vecs[7]  = '{32'h3F800000, 32'h00000001, 32'h00000001, 1'b0};
      vecs[8]  = '{32'hBF800000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
      vecs[9]  = '{32'h4B800000, 32'h01000000, 32'h01000000, 1'b0};
      vecs[10] = '{32'h4EFFFFFF, 32'h7FFFFF80, 32'h7FFFFF80, 1'b0};
      vecs[11] = '{32'h4AFFFFFF, 32'h007FFFFF, 32'h007FFFFF, 1'b0};
      vecs[12] = '{32'h7F800000, 32'h80000000, 32'h7FFFFFFF, 1'b1};
      vecs[13] = '{32'hFF800000, 32'h80000000, 32'h80000000, 1'b1};
      vecs[14] = '{32'hCF000001, 32'h80000000, 32'h80000000, 1'b1};
      vecs[15] = '{32'h00000001, 32'h00000000, 32'h00000000, 1'b0};
      vecs[16] = '{32'hCEFFFFFF, 32'h80000080, 32'h80000080, 1'b0};

      strm[0] = '{32'h3F800000, 32'd1, 32'd1, 1'b0};
      strm[1] = '{32'h40000000, 32'd2, 32'd2, 1'b0};
      strm[2] = '{32'h40400000, 32'd3, 32'd3, 1'b0};
      strm[3] = '{32'h40800000, 32'd4, 32'd4, 1'b0};
      strm[4] = '{32'h40A00000, 32'd5, 32'd5, 1'b0};
      strm[5] = '{32'h40C00000, 32'd6, 32'd6, 1'b0};
      strm[6] = '{32'h40E00000, 32'd7, 32'd7, 1'b0};
      strm[7] = '{32'h41000000, 32'd8, 32'd8, 1'b0};

      // Reset state
      #2;
      chk("reset_out_valid", {32'd0, out_valid}, 33'd0);
      chk("reset_y_ovf", {y, ovf_w}, 33'd0);
      chk("reset_in_ready", {32'd0, in_ready}, 33'd1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Single op latency: out_valid appears two edges after accept
      send('{32'h40490FDB, 32'd3, 32'd3, 1'b0});
      in_valid = 1'b0;
      #1 chk("latency_cycle1_no_valid", {32'd0, out_valid}, 33'd0);
      @(negedge clk);
      #1 chk("latency_cycle2_valid", {32'd0, out_valid}, 33'd1);
      @(negedge clk);
      drain();

      // Directed vectors back to back
      foreach (vecs[i]) send(vecs[i]);
      in_valid = 1'b0;
      drain();

      // Streaming with out_ready low for cycles 3..6
      p0 = pops;
      fork
         begin
            foreach (strm[i]) send(strm[i]);
            in_valid = 1'b0;
         end
         begin
            repeat (3) @(negedge clk);
            out_ready = 1'b0;
            repeat (3) @(negedge clk);
            #1 chk("stall_in_ready_low", {32'd0, in_ready}, 33'd0);
            @(negedge clk);
            out_ready = 1'b1;
         end
      join
      drain();
      chk("stream_count", 33'(pops - p0), 33'd8);

      // Reset with two ops in flight
      out_ready = 1'b0;
      send(strm[0]);
      send(strm[1]);
      in_valid = 1'b0;
      rst = 1'b1;
      q.delete();
      #1;
      chk("midreset_out_valid", {32'd0, out_valid}, 33'd0);
      chk("midreset_y", {1'b0, y}, 33'd0);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      p0 = pops;
      send('{32'h40A00000, 32'd5, 32'd5, 1'b0});
      in_valid = 1'b0;
      repeat (6) @(negedge clk);
      chk("post_reset_count", 33'(pops - p0), 33'd1);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule

`default_nettype wire
